// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the issue-side handshake, the ALU operand/result
// path and the writeback handshake of the alu_issue block.
//   slave  - view used by alu_issue itself
//   master - view used by the surrounding pipeline (register read, ALU, WB)
interface alu_issue_if;
    // register-read side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    // ALU side
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    // writeback side
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    // status
    logic        illegal;
    logic [7:0]  illegal_count;

    modport slave (
        input  in_valid,
        output in_ready,
        input  instr,
        input  rs1_val,
        input  rs2_val,
        output alu_op,
        output op_a,
        output op_b,
        input  alu_result,
        output wb_valid,
        input  wb_ready,
        output wb_rd,
        output wb_data,
        output illegal,
        output illegal_count
    );

    modport master (
        output in_valid,
        input  in_ready,
        output instr,
        output rs1_val,
        output rs2_val,
        input  alu_op,
        input  op_a,
        input  op_b,
        output alu_result,
        input  wb_valid,
        output wb_ready,
        input  wb_rd,
        input  wb_data,
        input  illegal,
        input  illegal_count
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: issue/decode front-end for a registered (1-cycle) ALU.
// Decodes RV32 R-type (and optionally I-type) integer ops into a 4-bit
// ALUOp, drives ALU operands from registers and tags the ALU result with
// its destination register for writeback under valid/ready.
//
// Build option: define ALU_ISSUE_IMM_EN to decode I-type (opcode 0010011).
// Without it, I-type instructions are reported as illegal.
module alu_issue (
    input  logic          clk,
    input  logic          rst,
    alu_issue_if.slave    io
);
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [3:0]  alu_op_reg;
    logic [31:0] op_a_reg;
    logic [31:0] op_b_reg;
    logic [4:0]  wb_rd_reg;
    logic        wb_valid_reg;
    logic        illegal_reg;
    logic [7:0]  illegal_count_reg;

    // instruction fields
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    assign opcode = io.instr[6:0];
    assign f3     = io.instr[14:12];
    assign f7     = io.instr[31:25];

    // decode results
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic        dec_shift;
    logic [31:0] dec_b_raw;
    logic [31:0] dec_b;

`ifdef ALU_ISSUE_IMM_EN
    logic [31:0] imm_sext;
    logic [31:0] imm_shamt;
    assign imm_sext  = {{20{io.instr[31]}}, io.instr[31:20]};
    assign imm_shamt = {27'd0, io.instr[24:20]};
`endif

    // handshake
    logic accept;
    assign io.in_ready = (state_reg == ST_IDLE) ||
                         ((state_reg == ST_WB) && io.wb_ready);
    assign accept      = io.in_valid && io.in_ready;

    // Decode funct3/funct7 into ALUOp, legality and the raw opB source
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        dec_shift = 1'b0;
        dec_b_raw = io.rs2_val;
        case (opcode)
            OPC_R: begin
                dec_b_raw = io.rs2_val;
                case (f3)
                    3'b000: begin
                        if (f7 == F7_ZERO) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ADD;
                        end else if (f7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SUB;
                        end
                    end
                    3'b111: begin
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = OP_AND;
                    end
                    3'b110: begin
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = OP_OR;
                    end
                    3'b100: begin
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = OP_XOR;
                    end
                    3'b001: begin
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = OP_SLL;
                        dec_shift = 1'b1;
                    end
                    3'b101: begin
                        // SRA (f7 0100000) is not supported by the ALU
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = OP_SRL;
                        dec_shift = 1'b1;
                    end
                    default: dec_legal = 1'b0;   // SLT/SLTU
                endcase
            end
`ifdef ALU_ISSUE_IMM_EN
            OPC_I: begin
                dec_b_raw = imm_sext;
                case (f3)
                    3'b000: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ADD;
                    end
                    3'b111: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_AND;
                    end
                    3'b110: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_OR;
                    end
                    3'b100: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_XOR;
                    end
                    3'b001: begin
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = OP_SLL;
                        dec_shift = 1'b1;
                        dec_b_raw = imm_shamt;
                    end
                    3'b101: begin
                        // SRAI shares f3 with SRLI; only f7 0000000 is legal
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = OP_SRL;
                        dec_shift = 1'b1;
                        dec_b_raw = imm_shamt;
                    end
                    default: dec_legal = 1'b0;   // SLTI/SLTIU
                endcase
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    // Shift amounts are masked to 5 bits so the ALU never sees a wide shift
    assign dec_b = dec_shift ? {27'd0, dec_b_raw[4:0]} : dec_b_raw;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: legal accepts go to EXEC, everything else settles in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && dec_legal) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_WB;
            end
            ST_WB: begin
                if (io.wb_ready) begin
                    state_next = (accept && dec_legal) ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Issue registers: loaded only on a legal accept, held through EXEC/WB
    // so the ALU keeps recomputing the same result while writeback stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_reg <= OP_ADD;
            op_a_reg   <= 32'd0;
            op_b_reg   <= 32'd0;
            wb_rd_reg  <= 5'd0;
        end else if (accept && dec_legal) begin
            alu_op_reg <= dec_op;
            op_a_reg   <= io.rs1_val;
            op_b_reg   <= dec_b;
            wb_rd_reg  <= io.instr[11:7];
        end
    end

    // Writeback valid mirrors the WB state one register stage ahead
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_reg <= 1'b0;
        end else begin
            wb_valid_reg <= (state_next == ST_WB);
        end
    end

    // Illegal pulse and wrapping illegal counter
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_reg       <= 1'b0;
            illegal_count_reg <= 8'd0;
        end else begin
            illegal_reg <= accept && !dec_legal;
            if (accept && !dec_legal) begin
                illegal_count_reg <= illegal_count_reg + 8'd1;
            end
        end
    end

    assign io.alu_op        = alu_op_reg;
    assign io.op_a          = op_a_reg;
    assign io.op_b          = op_b_reg;
    assign io.wb_rd         = wb_rd_reg;
    assign io.wb_valid      = wb_valid_reg;
    assign io.wb_data       = io.alu_result;
    assign io.illegal       = illegal_reg;
    assign io.illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized + directed bench for alu_issue with a registered
// ALU model in the environment and an instruction-level reference model.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if io();

    alu_issue dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    // Environment ALU: registered result, one cycle behind its operands
    always @(posedge clk) begin
        case (io.alu_op)
            4'b0000: io.alu_result <= io.op_a + io.op_b;
            4'b0001: io.alu_result <= io.op_a - io.op_b;
            4'b0010: io.alu_result <= io.op_a & io.op_b;
            4'b0011: io.alu_result <= io.op_a | io.op_b;
            4'b0100: io.alu_result <= io.op_a ^ io.op_b;
            4'b0101: io.alu_result <= io.op_a << io.op_b[4:0];
            4'b0110: io.alu_result <= io.op_a >> io.op_b[4:0];
            default: io.alu_result <= 32'd0;
        endcase
    end

    int total = 0;
    int bad   = 0;
    logic [7:0]  model_cnt = 8'd0;
    logic [31:0] last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: what the instruction means, the operands
    // the ALU must see, and the architectural result.
    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b, output logic legal,
                                      output logic [3:0] op, output logic [31:0] ob,
                                      output logic [31:0] res);
        logic [6:0] opc;
        logic [2:0] fn3;
        logic [6:0] fn7;
        opc = ins[6:0];
        fn3 = ins[14:12];
        fn7 = ins[31:25];
        legal = 1'b0;
        op = 4'd0;
        ob = b;
        res = 32'd0;
        if (opc == 7'b0110011) begin
            ob = b;
            if (fn3 == 3'b000 && fn7 == 7'h00) begin legal = 1; op = 4'd0; end
            if (fn3 == 3'b000 && fn7 == 7'h20) begin legal = 1; op = 4'd1; end
            if (fn3 == 3'b111 && fn7 == 7'h00) begin legal = 1; op = 4'd2; end
            if (fn3 == 3'b110 && fn7 == 7'h00) begin legal = 1; op = 4'd3; end
            if (fn3 == 3'b100 && fn7 == 7'h00) begin legal = 1; op = 4'd4; end
            if (fn3 == 3'b001 && fn7 == 7'h00) begin legal = 1; op = 4'd5; ob = b % 32; end
            if (fn3 == 3'b101 && fn7 == 7'h00) begin legal = 1; op = 4'd6; ob = b % 32; end
        end
`ifdef ALU_ISSUE_IMM_EN
        if (opc == 7'b0010011) begin
            ob = {{20{ins[31]}}, ins[31:20]};
            if (fn3 == 3'b000) begin legal = 1; op = 4'd0; end
            if (fn3 == 3'b111) begin legal = 1; op = 4'd2; end
            if (fn3 == 3'b110) begin legal = 1; op = 4'd3; end
            if (fn3 == 3'b100) begin legal = 1; op = 4'd4; end
            if (fn3 == 3'b001 && fn7 == 7'h00) begin legal = 1; op = 4'd5; ob = 32'(ins[24:20]); end
            if (fn3 == 3'b101 && fn7 == 7'h00) begin legal = 1; op = 4'd6; ob = 32'(ins[24:20]); end
        end
`endif
        case (op)
            4'd0: res = a + ob;
            4'd1: res = a - ob;
            4'd2: res = a & ob;
            4'd3: res = a | ob;
            4'd4: res = a ^ ob;
            4'd5: res = a << ob;
            default: res = a >> ob;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] fn7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] fn3,
                                       input logic [4:0] rd, input logic [6:0] opc);
        return {fn7, r2, r1, fn3, rd, opc};
    endfunction

    // One transaction from IDLE back to IDLE; 'hold' = cycles of WB stall.
    // Entry/exit time: 1 time unit after a rising edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic legal;
        logic [3:0] op;
        logic [31:0] ob, res;
        ref_model(ins, a, b, legal, op, ob, res);
        io.in_valid = 1'b1;
        io.instr    = ins;
        io.rs1_val  = a;
        io.rs2_val  = b;
        io.wb_ready = 1'b1;
        #1;
        check("in_ready_idle", 32'(io.in_ready), 32'd1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.instr    = $urandom;
        if (legal) begin
            check("alu_op", 32'(io.alu_op), 32'(op));
            check("op_a", io.op_a, a);
            check("op_b", io.op_b, ob);
            check("exec_wb_valid", 32'(io.wb_valid), 32'd0);
            @(posedge clk); #1;
            check("wb_valid", 32'(io.wb_valid), 32'd1);
            check("wb_rd", 32'(io.wb_rd), 32'(ins[11:7]));
            check("wb_data", io.wb_data, res);
            last_data = io.wb_data;
            if (hold > 0) io.wb_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("stall_wb_valid", 32'(io.wb_valid), 32'd1);
                check("stall_wb_data", io.wb_data, res);
                check("stall_wb_rd", 32'(io.wb_rd), 32'(ins[11:7]));
                check("stall_in_ready", 32'(io.in_ready), 32'd0);
            end
            io.wb_ready = 1'b1;
            @(posedge clk); #1;
            check("wb_done", 32'(io.wb_valid), 32'd0);
        end else begin
            model_cnt = model_cnt + 8'd1;
            check("illegal_pulse", 32'(io.illegal), 32'd1);
            check("illegal_count", 32'(io.illegal_count), 32'(model_cnt));
            check("illegal_no_wb", 32'(io.wb_valid), 32'd0);
            @(posedge clk); #1;
            check("illegal_drop", 32'(io.illegal), 32'd0);
            check("illegal_idle_wb", 32'(io.wb_valid), 32'd0);
        end
        $display("txn instr=%h a=%h b=%h legal=%0d res=%h hold=%0d", ins, a, b, legal, res, hold);
    endtask

    initial begin
        logic [31:0] ins, a, b;
        logic [6:0] opc, fn7;
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.instr    = 32'd0;
        io.rs1_val  = 32'd0;
        io.rs2_val  = 32'd0;
        io.wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_op", 32'(io.alu_op), 32'd0);
        check("rst_op_a", io.op_a, 32'd0);
        check("rst_op_b", io.op_b, 32'd0);
        check("rst_wb_rd", 32'(io.wb_rd), 32'd0);
        check("rst_wb_valid", 32'(io.wb_valid), 32'd0);
        check("rst_illegal", 32'(io.illegal), 32'd0);
        check("rst_count", 32'(io.illegal_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD x3,x1,x2
        issue(mk(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'd5, 32'd7, 0);
        check("add_const", last_data, 32'd12);
        // SUB
        issue(mk(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011), 32'd3, 32'd5, 1);
        check("sub_const", last_data, 32'hFFFFFFFE);
        // SLL with wide rs2
        issue(mk(7'h00, 5'd2, 5'd1, 3'b001, 5'd5, 7'b0110011), 32'd1, 32'h21, 0);
        check("sll_const", last_data, 32'd2);
        // SRLI 31 and ADDI -1 (illegal when immediates are disabled)
        issue(mk(7'h00, 5'd31, 5'd1, 3'b101, 5'd6, 7'b0010011), 32'h80000000, 32'd0, 0);
        issue({12'hFFF, 5'd1, 3'b000, 5'd7, 7'b0010011}, 32'd10, 32'd0, 2);
        // rd = 0 issued normally
        issue(mk(7'h00, 5'd2, 5'd1, 3'b110, 5'd0, 7'b0110011), 32'hF0, 32'h0F, 0);
        // stall 5 cycles
        issue(mk(7'h00, 5'd2, 5'd1, 3'b100, 5'd9, 7'b0110011), 32'hAAAA5555, 32'hFFFF0000, 5);

        // back-to-back: stall in WB with the next instruction waiting
        io.in_valid = 1'b1;
        io.instr    = mk(7'h00, 5'd2, 5'd1, 3'b111, 5'd10, 7'b0110011);
        io.rs1_val  = 32'h1234;
        io.rs2_val  = 32'h00FF;
        io.wb_ready = 1'b1;
        @(posedge clk); #1;                 // accept AND -> EXEC
        io.instr    = mk(7'h20, 5'd2, 5'd1, 3'b000, 5'd11, 7'b0110011);
        io.rs1_val  = 32'd100;
        io.rs2_val  = 32'd1;
        io.wb_ready = 1'b0;
        @(posedge clk); #1;                 // WB
        check("b2b_wb_valid", 32'(io.wb_valid), 32'd1);
        check("b2b_wb_data", io.wb_data, 32'h0034);
        check("b2b_hold_ready", 32'(io.in_ready), 32'd0);
        io.wb_ready = 1'b1;
        #1;
        check("b2b_release_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk); #1;                 // WB done, SUB accepted -> EXEC
        check("b2b_exec_wb_valid", 32'(io.wb_valid), 32'd0);
        check("b2b_alu_op", 32'(io.alu_op), 32'd1);
        check("b2b_op_a", io.op_a, 32'd100);
        io.instr    = mk(7'h20, 5'd2, 5'd1, 3'b101, 5'd12, 7'b0110011);  // SRA
        @(posedge clk); #1;                 // WB, illegal waiting
        check("b2b_wb2_data", io.wb_data, 32'd99);
        check("b2b_wb2_rd", 32'(io.wb_rd), 32'd11);
        @(posedge clk); #1;                 // WB done, illegal accepted -> IDLE
        io.in_valid = 1'b0;
        model_cnt = model_cnt + 8'd1;
        check("wb_illegal_pulse", 32'(io.illegal), 32'd1);
        check("wb_illegal_wbv", 32'(io.wb_valid), 32'd0);
        check("wb_illegal_cnt", 32'(io.illegal_count), 32'(model_cnt));
        check("wb_illegal_idle", 32'(io.in_ready), 32'd1);
        check("wb_illegal_hold_op", 32'(io.alu_op), 32'd1);
        $display("txn back-to-back AND/SUB/SRA sequence");
        @(posedge clk); #1;

        // 256 illegals: counter wraps back to its starting value
        a = 32'(model_cnt);
        for (int i = 0; i < 256; i++) begin
            issue(mk(7'h20, 5'($urandom), 5'd1, 3'b101, 5'($urandom), 7'b0110011),
                  $urandom, $urandom, 0);
        end
        check("count_wrap", 32'(io.illegal_count), a);

        // randomized mix
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0: opc = 7'b0110011;
                1: opc = 7'b0010011;
                default: opc = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1: fn7 = 7'h00;
                2: fn7 = 7'h20;
                default: fn7 = 7'($urandom);
            endcase
            ins = mk(fn7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc);
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            issue(ins, a, b, $urandom_range(0, 3));
        end

        // reset while EXEC: nothing reaches writeback
        io.in_valid = 1'b1;
        io.instr    = mk(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
        io.rs1_val  = 32'd5;
        io.rs2_val  = 32'd7;
        io.wb_ready = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 8'd0;
        check("rst_exec_wbv", 32'(io.wb_valid), 32'd0);
        check("rst_exec_op", 32'(io.alu_op), 32'd0);
        check("rst_exec_a", io.op_a, 32'd0);
        check("rst_exec_b", io.op_b, 32'd0);
        check("rst_exec_rd", 32'(io.wb_rd), 32'd0);
        check("rst_exec_cnt", 32'(io.illegal_count), 32'd0);
        @(posedge clk); #1;
        check("rst_exec_wbv2", 32'(io.wb_valid), 32'd0);
        check("rst_exec_ready", 32'(io.in_ready), 32'd1);
        $display("txn reset during EXEC");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
